branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Execute-side counterpart of the branch predictor. Buffers in-flight predictions (pc, history index, target, taken) issued by fetch.
- Pairs each prediction, in order, with the actual branch outcome from execute.
- Emits the resolution bundle (res_*) that trains the predictor, plus a front-end redirect on mispredict.

Parameters:
- DEPTH, 4, in-flight prediction queue entries; power of 2, >=2
- XLEN, mmm_pkg::XLEN, address/target width
- HLEN, mmm_pkg::HLEN, gshare index width

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active-low
- flush_i  in  1  pipeline flush, synchronous
- pred_valid_i  in  1  fetch pushes a prediction for a branch
- pred_ready_o  out  1  queue not full
- pred_pc_i  in  XLEN  branch pc
- pred_index_i  in  HLEN  gshare index used for the prediction
- pred_target_i  in  XLEN  predicted target
- pred_taken_i  in  1  predicted direction
- exe_valid_i  in  1  execute has resolved the oldest branch
- exe_ready_o  out  1  queue not empty
- exe_taken_i  in  1  actual direction
- exe_target_i  in  XLEN  actual taken target
- res_valid_o  out  1  resolution valid, one-cycle pulse
- res_pc_o  out  XLEN  resolved branch pc
- res_index_o  out  HLEN  stored gshare index
- res_target_o  out  XLEN  actual target (exe_target_i)
- res_taken_o  out  1  actual direction
- res_mispredict_o  out  1  prediction was wrong
- redirect_valid_o  out  1  front-end must refetch
- redirect_pc_o  out  XLEN  correct next pc

Behaviour:
- Reset: queue empty, pointers 0, all res_* and redirect_* = 0; pred_ready_o=1, exe_ready_o=0.
- Queue: circular FIFO with rd/wr pointers of log2(DEPTH) bits plus an occupancy counter of log2(DEPTH)+1 bits.
  - Push when pred_valid_i & pred_ready_o.
  - Pop when exe_valid_i & exe_ready_o.
  - Pointers wrap modulo DEPTH.
  - Full: push blocked, even with a simultaneous pop (no fall-through).
  - Empty: exe_valid_i ignored; no bypass of a same-cycle push.
- Resolution: combinational compare on the head entry; res_* and redirect_* are registered, latency 1 cycle after the pop.
  - mispredict = (pred_taken != exe_taken) | (pred_taken & exe_taken & pred_target != exe_target).
  - redirect_pc = exe_taken ? exe_target_i : head.pc + 4 (XLEN modulo add, wraps).
  - redirect_valid_o = res_valid_o & res_mispredict_o.
  - Outputs hold their values; res_valid_o and redirect_valid_o are single-cycle pulses.
- Mispredict: on the popping edge, the whole queue is cleared (younger entries are wrong-path), and any same-cycle push is dropped.
- flush_i, highest priority: clears the queue, drops any push or pop, and forces res_valid_o = redirect_valid_o = 0 on the next cycle.
- rst_n_i asserted mid-operation returns everything to reset state immediately.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined: adds outputs perf_branches_o[31:0] and perf_mispred_o[31:0].
  - perf_branches_o increments on every res_valid_o; perf_mispred_o increments on every redirect_valid_o.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and are unaffected by flush_i.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- mmm_pkg: XLEN, HLEN; new typedef pred_entry_t (pc, index, target, taken) and res_bundle_t (valid, pc, index, target, taken, mispredict).
- Sub-module pred_queue: parameterized FIFO of pred_entry_t with push/pop/clear/full/empty. branch_resolver owns the compare, output registers and counters.

Test Plan:
- Reset, push pc=0x100, idx=5, tgt=0x200, taken=1; exe taken=1, tgt=0x200 -> next cycle res_valid=1, res_mispredict=0, redirect_valid=0, res_index=5.
- Push predicted not-taken pc=0x40; exe taken=1, tgt=0x80 -> res_mispredict=1, redirect_valid=1, redirect_pc=0x80; queue emptied (exe_ready_o=0).
- Push predicted taken pc=0x40, tgt=0x80; exe taken=1, tgt=0x90 -> res_mispredict=1, redirect_pc=0x90.
- Push predicted taken pc=0x40; exe not-taken -> redirect_pc=0x44.
- Push pc=0xFFFF_FFFC predicted taken; exe not-taken -> redirect_pc=0x0 (wrap).
- Push DEPTH entries -> pred_ready_o=0.
  - A 5th push while full is blocked, including with a simultaneous pop.
  - Pops then return entries in order, and pointers wrap correctly over 3×DEPTH traffic.
- With 3 entries queued, assert flush_i in the same cycle as exe_valid_i -> no res_valid next cycle, exe_ready_o=0.
  - With BRU_PERF_CNT_EN defined, the counters are unchanged by the flush.

Source files
------------

// File: rtl/mmm_pkg.sv
// Shared branch-unit definitions: address/history widths, the in-flight
// prediction entry, the resolution bundle and small compare helpers.
package mmm_pkg;

  localparam int XLEN = 32;
  localparam int HLEN = 10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [HLEN-1:0] index;
    logic [XLEN-1:0] target;
    logic            taken;
  } pred_entry_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [HLEN-1:0] index;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            mispredict;
  } res_bundle_t;

  // A prediction is wrong if the direction differs, or both say taken but
  // the targets disagree.
  function automatic logic is_mispredict(input logic            pred_taken,
                                         input logic [XLEN-1:0] pred_target,
                                         input logic            exe_taken,
                                         input logic [XLEN-1:0] exe_target);
    return (pred_taken != exe_taken) |
           (pred_taken & exe_taken & (pred_target != exe_target));
  endfunction

  // Sequential next pc; wraps modulo 2**XLEN.
  function automatic logic [XLEN-1:0] fallthrough_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Handshake/bus bundle between fetch/execute and the branch resolver.
// master = fetch/execute side, slave = branch_resolver.
interface branch_resolver_if #(
  parameter int XLEN = mmm_pkg::XLEN,
  parameter int HLEN = mmm_pkg::HLEN
);
  logic            pred_valid_i;
  logic            pred_ready_o;
  logic [XLEN-1:0] pred_pc_i;
  logic [HLEN-1:0] pred_index_i;
  logic [XLEN-1:0] pred_target_i;
  logic            pred_taken_i;
  logic            exe_valid_i;
  logic            exe_ready_o;
  logic            exe_taken_i;
  logic [XLEN-1:0] exe_target_i;
  logic            res_valid_o;
  logic [XLEN-1:0] res_pc_o;
  logic [HLEN-1:0] res_index_o;
  logic [XLEN-1:0] res_target_o;
  logic            res_taken_o;
  logic            res_mispredict_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    output pred_valid_i, pred_pc_i, pred_index_i, pred_target_i, pred_taken_i,
    output exe_valid_i, exe_taken_i, exe_target_i,
    input  pred_ready_o, exe_ready_o,
    input  res_valid_o, res_pc_o, res_index_o, res_target_o, res_taken_o,
    input  res_mispredict_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    input  pred_valid_i, pred_pc_i, pred_index_i, pred_target_i, pred_taken_i,
    input  exe_valid_i, exe_taken_i, exe_target_i,
    output pred_ready_o, exe_ready_o,
    output res_valid_o, res_pc_o, res_index_o, res_target_o, res_taken_o,
    output res_mispredict_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/pred_queue.sv
// In-order circular FIFO of in-flight predictions. No fall-through: a push
// while full is refused even if a pop happens in the same cycle, and a pop
// while empty is ignored. clear empties the queue and drops same-cycle ops.
module pred_queue
  import mmm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  pred_entry_t push_data,
  input  logic        pop,
  output pred_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pred_entry_t     mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            push_ok_s;
  logic            pop_ok_s;

  // Status flags and qualified push/pop.
  always_comb begin
    full      = (count_r == CW'(DEPTH));
    empty     = (count_r == CW'(0));
    push_ok_s = push & ~full & ~clear;
    pop_ok_s  = pop & ~empty & ~clear;
    head      = mem_r[rd_ptr_r];
  end

  // Pointers wrap naturally at AW bits; occupancy tracks push minus pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: queues predictions from fetch, pairs the oldest with the
// execute outcome, and emits a registered resolution bundle plus a
// front-end redirect on mispredict. A mispredict or flush empties the queue.
// Optional BRU_PERF_CNT_EN adds saturating branch/mispredict counters.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int XLEN  = mmm_pkg::XLEN,
  parameter int HLEN  = mmm_pkg::HLEN
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic flush_i,
  branch_resolver_if.slave bus
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0] perf_branches_o,
  output logic [31:0] perf_mispred_o
`endif
);
  import mmm_pkg::*;

  pred_entry_t     push_entry_s;
  pred_entry_t     head_s;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic            mispredict_s;
  logic            clear_s;
  logic [XLEN-1:0] redirect_pc_s;

  res_bundle_t     res_r;
  logic            redirect_valid_r;
  logic [XLEN-1:0] redirect_pc_r;

  // Handshakes, head compare and queue clear (flush or resolved mispredict).
  always_comb begin
    push_s        = bus.pred_valid_i & ~full_s;
    pop_s         = bus.exe_valid_i & ~empty_s;
    mispredict_s  = is_mispredict(head_s.taken, head_s.target,
                                  bus.exe_taken_i, bus.exe_target_i);
    clear_s       = flush_i | (pop_s & mispredict_s);
    redirect_pc_s = bus.exe_taken_i ? bus.exe_target_i : fallthrough_pc(head_s.pc);
    push_entry_s  = '{pc:     bus.pred_pc_i,
                      index:  bus.pred_index_i,
                      target: bus.pred_target_i,
                      taken:  bus.pred_taken_i};
  end

  pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .clear     (clear_s),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Resolution registers: load on pop, valids pulse for one cycle, flush wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_r            <= '0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
    end else if (flush_i) begin
      res_r.valid      <= 1'b0;
      redirect_valid_r <= 1'b0;
    end else if (pop_s) begin
      res_r            <= '{valid:      1'b1,
                            pc:         head_s.pc,
                            index:      head_s.index,
                            target:     bus.exe_target_i,
                            taken:      bus.exe_taken_i,
                            mispredict: mispredict_s};
      redirect_valid_r <= mispredict_s;
      redirect_pc_r    <= redirect_pc_s;
    end else begin
      res_r.valid      <= 1'b0;
      redirect_valid_r <= 1'b0;
    end
  end

  assign bus.pred_ready_o     = ~full_s;
  assign bus.exe_ready_o      = ~empty_s;
  assign bus.res_valid_o      = res_r.valid;
  assign bus.res_pc_o         = XLEN'(res_r.pc);
  assign bus.res_index_o      = HLEN'(res_r.index);
  assign bus.res_target_o     = XLEN'(res_r.target);
  assign bus.res_taken_o      = res_r.taken;
  assign bus.res_mispredict_o = res_r.mispredict;
  assign bus.redirect_valid_o = redirect_valid_r;
  assign bus.redirect_pc_o    = redirect_pc_r;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches_r;
  logic [31:0] perf_mispred_r;

  // Saturating event counters driven by the output pulses; flush has no effect.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_branches_r <= 32'd0;
      perf_mispred_r  <= 32'd0;
    end else begin
      if (res_r.valid && (perf_branches_r != 32'hFFFF_FFFF))
        perf_branches_r <= perf_branches_r + 32'd1;
      if (redirect_valid_r && (perf_mispred_r != 32'hFFFF_FFFF))
        perf_mispred_r <= perf_mispred_r + 32'd1;
    end
  end

  assign perf_branches_o = perf_branches_r;
  assign perf_mispred_o  = perf_mispred_r;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_branch_resolver;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int HLEN  = 10;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic flush_i;

  always #5 clk_i = ~clk_i;

  branch_resolver_if #(.XLEN(XLEN), .HLEN(HLEN)) bus ();

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches_o;
  logic [31:0] perf_mispred_o;
`endif

  branch_resolver #(.DEPTH(DEPTH), .XLEN(XLEN), .HLEN(HLEN)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .bus     (bus)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches_o (perf_branches_o),
    .perf_mispred_o  (perf_mispred_o)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [9:0]  idx;
    logic [31:0] tgt;
    logic        taken;
  } ent_t;

  ent_t q[$];
  int checks   = 0;
  int failures = 0;

  logic        exp_valid, exp_taken, exp_mis, exp_rv;
  logic [31:0] exp_pc, exp_tgt, exp_rpc;
  logic [9:0]  exp_idx;
  logic [31:0] exp_br, exp_mp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_valid = 1'b0; exp_taken = 1'b0; exp_mis = 1'b0; exp_rv = 1'b0;
    exp_pc = 32'd0; exp_tgt = 32'd0; exp_rpc = 32'd0; exp_idx = 10'd0;
    exp_br = 32'd0; exp_mp = 32'd0;
  endtask

  task automatic check_all();
    check("res_valid",      {63'd0, bus.res_valid_o},      {63'd0, exp_valid});
    check("res_pc",         {32'd0, bus.res_pc_o},         {32'd0, exp_pc});
    check("res_index",      {54'd0, bus.res_index_o},      {54'd0, exp_idx});
    check("res_target",     {32'd0, bus.res_target_o},     {32'd0, exp_tgt});
    check("res_taken",      {63'd0, bus.res_taken_o},      {63'd0, exp_taken});
    check("res_mispredict", {63'd0, bus.res_mispredict_o}, {63'd0, exp_mis});
    check("redirect_valid", {63'd0, bus.redirect_valid_o}, {63'd0, exp_rv});
    check("redirect_pc",    {32'd0, bus.redirect_pc_o},    {32'd0, exp_rpc});
    check("pred_ready",     {63'd0, bus.pred_ready_o},     {63'd0, (q.size() < DEPTH)});
    check("exe_ready",      {63'd0, bus.exe_ready_o},      {63'd0, (q.size() > 0)});
`ifdef BRU_PERF_CNT_EN
    check("perf_branches",  {32'd0, perf_branches_o},      {32'd0, exp_br});
    check("perf_mispred",   {32'd0, perf_mispred_o},       {32'd0, exp_mp});
`endif
  endtask

  // One clock: drive inputs, advance the model, then check at the next negedge.
  task automatic step(input logic pv, input logic [31:0] pc, input logic [9:0] idx,
                      input logic [31:0] tgt, input logic pt, input logic ev,
                      input logic et, input logic [31:0] etgt, input logic fl);
    bit   push_ok, pop_ok, mis;
    ent_t h;
    bus.pred_valid_i  = pv;
    bus.pred_pc_i     = pc;
    bus.pred_index_i  = idx;
    bus.pred_target_i = tgt;
    bus.pred_taken_i  = pt;
    bus.exe_valid_i   = ev;
    bus.exe_taken_i   = et;
    bus.exe_target_i  = etgt;
    flush_i           = fl;
    if (exp_valid && exp_br != 32'hFFFF_FFFF) exp_br = exp_br + 32'd1;
    if (exp_rv && exp_mp != 32'hFFFF_FFFF)    exp_mp = exp_mp + 32'd1;
    push_ok = pv && (q.size() < DEPTH);
    pop_ok  = ev && (q.size() > 0);
    if (fl) begin
      q.delete();
      exp_valid = 1'b0;
      exp_rv    = 1'b0;
    end else if (pop_ok) begin
      h   = q.pop_front();
      mis = (h.taken != et) || (h.taken && et && h.tgt != etgt);
      exp_valid = 1'b1; exp_pc = h.pc; exp_idx = h.idx; exp_tgt = etgt;
      exp_taken = et;   exp_mis = mis; exp_rv = mis;
      exp_rpc   = et ? etgt : h.pc + 32'd4;
      if (mis) q.delete();
      else if (push_ok) q.push_back('{pc, idx, tgt, pt});
    end else begin
      exp_valid = 1'b0;
      exp_rv    = 1'b0;
      if (push_ok) q.push_back('{pc, idx, tgt, pt});
    end
    @(negedge clk_i);
    check_all();
  endtask

  task automatic push_only(input logic [31:0] pc, input logic [9:0] idx,
                           input logic [31:0] tgt, input logic pt);
    step(1'b1, pc, idx, tgt, pt, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic pop_only(input logic et, input logic [31:0] etgt);
    step(1'b0, 32'd0, 10'd0, 32'd0, 1'b0, 1'b1, et, etgt, 1'b0);
  endtask

  task automatic apply_reset();
    bus.pred_valid_i = 1'b0; bus.exe_valid_i = 1'b0; flush_i = 1'b0;
    rst_n_i = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    check_all();
  endtask

  initial begin
    bus.pred_valid_i = 1'b0; bus.pred_pc_i = 32'd0; bus.pred_index_i = 10'd0;
    bus.pred_target_i = 32'd0; bus.pred_taken_i = 1'b0; bus.exe_valid_i = 1'b0;
    bus.exe_taken_i = 1'b0; bus.exe_target_i = 32'd0; flush_i = 1'b0; rst_n_i = 1'b0;
    @(negedge clk_i);
    apply_reset();
    check("reset_pred_ready", {63'd0, bus.pred_ready_o}, 64'd1);
    check("reset_exe_ready",  {63'd0, bus.exe_ready_o},  64'd0);

    // Correct taken prediction.
    push_only(32'h100, 10'd5, 32'h200, 1'b1);
    pop_only(1'b1, 32'h200);
    check("t1_valid", {63'd0, bus.res_valid_o},      64'd1);
    check("t1_mis",   {63'd0, bus.res_mispredict_o}, 64'd0);
    check("t1_rdv",   {63'd0, bus.redirect_valid_o}, 64'd0);
    check("t1_index", {54'd0, bus.res_index_o},      64'd5);

    // Predicted not-taken, actually taken; younger entry is discarded.
    push_only(32'h40, 10'd1, 32'h0, 1'b0);
    push_only(32'h50, 10'd2, 32'h0, 1'b0);
    pop_only(1'b1, 32'h80);
    check("t2_mis", {63'd0, bus.res_mispredict_o}, 64'd1);
    check("t2_rdv", {63'd0, bus.redirect_valid_o}, 64'd1);
    check("t2_rpc", {32'd0, bus.redirect_pc_o},    64'h80);
    check("t2_exe_ready", {63'd0, bus.exe_ready_o}, 64'd0);

    // Taken both ways, wrong target.
    push_only(32'h40, 10'd3, 32'h80, 1'b1);
    pop_only(1'b1, 32'h90);
    check("t3_mis", {63'd0, bus.res_mispredict_o}, 64'd1);
    check("t3_rpc", {32'd0, bus.redirect_pc_o},    64'h90);

    // Predicted taken, actually not-taken.
    push_only(32'h40, 10'd4, 32'h80, 1'b1);
    pop_only(1'b0, 32'h0);
    check("t4_rpc", {32'd0, bus.redirect_pc_o}, 64'h44);

    // Fall-through wraps.
    push_only(32'hFFFF_FFFC, 10'd6, 32'h80, 1'b1);
    pop_only(1'b0, 32'h0);
    check("t5_rpc", {32'd0, bus.redirect_pc_o}, 64'h0);

    // Fill, blocked push with simultaneous pop, in-order drain.
    for (int i = 0; i < DEPTH; i++) push_only(32'h1000 + 32'(i * 16), 10'(i), 32'h0, 1'b0);
    check("full_ready", {63'd0, bus.pred_ready_o}, 64'd0);
    step(1'b1, 32'h2000, 10'd9, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("full_pop_pc", {32'd0, bus.res_pc_o}, 64'h1000);
    for (int i = 1; i < DEPTH; i++) begin
      pop_only(1'b0, 32'h0);
      check("drain_pc", {32'd0, bus.res_pc_o}, 64'h1000 + 64'(i * 16));
    end
    check("drain_empty", {63'd0, bus.exe_ready_o}, 64'd0);

    // Flush in the same cycle as a pop.
    push_only(32'h300, 10'd1, 32'h0, 1'b0);
    push_only(32'h310, 10'd2, 32'h0, 1'b0);
    push_only(32'h320, 10'd3, 32'h0, 1'b0);
    step(1'b0, 32'h0, 10'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("flush_valid", {63'd0, bus.res_valid_o}, 64'd0);
    check("flush_exe_ready", {63'd0, bus.exe_ready_o}, 64'd0);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] etgt;
      if (n == 300) apply_reset();
      etgt = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[0].tgt : 32'($urandom_range(0, 3)) << 4;
      step($urandom_range(0, 9) < 6, $urandom & 32'hFFFF_FFFC, 10'($urandom),
           32'($urandom_range(0, 3)) << 4, 1'($urandom), $urandom_range(0, 9) < 5,
           1'($urandom), etgt, $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
